// File: rtl/combi_dmem_arbiter.sv
// combi_dmem_arbiter: round-robin arbiter sharing one single-ported data memory
// between the RISC-V (port 0) and ARM (port 1) cores, with a bounded hold lock.
module combi_dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

    logic          last_gnt;
    logic          lock_v;
    logic          lock_p;
    logic [HW-1:0] hold_cnt;
    logic          rd_pend0;
    logic          rd_pend1;
    logic          locked0;
    logic          locked1;
    logic          g0;
    logic          g1;
    logic          lk;
    logic [HW-1:0] nxt_cnt;

    // A held lock wins outright until it has been used MAX_HOLD times; after
    // that the owner is the last grantee, so round-robin hands over to the other port.
    always_comb begin
        locked0   = lock_v && !lock_p && req0 && (hold_cnt < HMAX);
        locked1   = lock_v && lock_p && req1 && (hold_cnt < HMAX);
        g0        = locked0 || (!locked1 && req0 && (!req1 || last_gnt));
        g1        = locked1 || (!locked0 && req1 && (!req0 || !last_gnt));
        gnt0      = reset && g0;
        gnt1      = reset && g1;
        mem_en    = gnt0 || gnt1;
        mem_we    = gnt0 ? we0 : gnt1 ? we1 : 1'b0;
        mem_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
        mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
        lk        = gnt0 ? lock0 : gnt1 ? lock1 : 1'b0;
        nxt_cnt   = !lk ? '0 :
                    (lock_v && lock_p == gnt1) ? ((hold_cnt == HMAX) ? HMAX : hold_cnt + HW'(1)) :
                    HW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_gnt <= 1'b1;
            lock_v   <= 1'b0;
            lock_p   <= 1'b0;
            hold_cnt <= '0;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rd_pend0 <= gnt0 && !we0;
            rd_pend1 <= gnt1 && !we1;
            if (mem_en)
                last_gnt <= gnt1;
            lock_v   <= lk;
            lock_p   <= gnt1;
            hold_cnt <= nxt_cnt;
        end
    end

    assign rvalid0 = rd_pend0;
    assign rvalid1 = rd_pend1;
    assign rdata0  = rd_pend0 ? mem_rdata : '0;
    assign rdata1  = rd_pend1 ? mem_rdata : '0;
endmodule

// File: tb/tb_combi_dmem_arbiter.sv
// tb_combi_dmem_arbiter: scoreboard bench; stimulus queues the hand-computed grant
// and read-return order, a negedge monitor pops and compares as the DUT presents them.
module tb_combi_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } g_t;
    typedef struct {
        logic        port;
        logic [31:0] data;
    } r_t;

    g_t gq[$];
    r_t rq[$];
    g_t g;
    r_t r;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    combi_dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic drv0(input logic r_, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        req0 = r_; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic drv1(input logic r_, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        req1 = r_; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    task automatic push_g(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
        gq.push_back('{port: p, we: w, addr: a, data: d});
    endtask

    task automatic push_r(input logic p, input logic [31:0] d);
        rq.push_back('{port: p, data: d});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected grant per mem_en cycle and one read per rvalid.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
            if (mem_en) begin
                if (gq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_grant: got gnt0=%b gnt1=%b expected none", gnt0, gnt1);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_port", 32'({gnt1, gnt0}), g.port ? 32'd2 : 32'd1);
                    chk("mem_we", 32'(mem_we), 32'(g.we));
                    chk("mem_addr", mem_addr, g.addr);
                    chk("mem_wdata", mem_wdata, g.data);
                end
            end else begin
                chk("idle_bus", 32'({gnt1, gnt0, mem_we}), 32'd0);
            end
            if (rvalid0 || rvalid1) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rvalid: got rvalid0=%b rvalid1=%b expected none", rvalid0, rvalid1);
                end else begin
                    r = rq.pop_front();
                    chk("rv_port", 32'({rvalid1, rvalid0}), r.port ? 32'd2 : 32'd1);
                    chk("rdata", r.port ? rdata1 : rdata0, r.data);
                    chk("rdata_other", r.port ? rdata0 : rdata1, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        mem_rdata = 32'd0;
        drv0(1, 1, 0, 100, 25);
        drv1(1, 1, 0, 100, 7);
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt0", 32'(gnt0), 32'd0);
            chk("rst_gnt1", 32'(gnt1), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
        end
        // contention after reset: port 0 first, then alternate
        step; reset = 1'b1; push_g(0, 1, 100, 25);
        @(negedge clk); chk("first_gnt0", 32'(gnt0), 32'd1);
        step; drv0(1, 1, 0, 104, 11); push_g(1, 1, 100, 7);
        step; drv1(1, 1, 0, 108, 8);  push_g(0, 1, 104, 11);
        step; drv0(0, 0, 0, 0, 0);    push_g(1, 1, 108, 8);
        // port 0 alone write
        step; drv1(0, 0, 0, 0, 0); drv0(1, 1, 0, 100, 25); push_g(0, 1, 100, 25);
        @(negedge clk);
        chk("solo_gnt0", 32'(gnt0), 32'd1);
        chk("solo_we", 32'(mem_we), 32'd1);
        chk("solo_addr", mem_addr, 32'd100);
        chk("solo_wdata", mem_wdata, 32'd25);
        step; drv0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("write_no_rvalid0", 32'(rvalid0), 32'd0);
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        // port 1 read, one-cycle return
        step; drv1(1, 0, 0, 96, 0); mem_rdata = 32'h1234; push_g(1, 0, 96, 0); push_r(1, 32'h1234);
        step; drv1(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("read_rvalid1", 32'(rvalid1), 32'd1);
        chk("read_rdata1", rdata1, 32'h1234);
        chk("read_rdata0", rdata0, 32'd0);
        // port 0 lock against a waiting port 1
        step; mem_rdata = 32'd0; drv0(1, 1, 1, 200, 1); drv1(1, 1, 0, 300, 9); push_g(0, 1, 200, 1);
        step; drv0(1, 1, 1, 204, 2); push_g(0, 1, 204, 2);
        step; drv0(1, 1, 1, 208, 3); push_g(0, 1, 208, 3);
        step; drv0(1, 1, 1, 212, 4); push_g(0, 1, 212, 4);
        step; drv0(1, 1, 1, 216, 5); push_g(1, 1, 300, 9);
        @(negedge clk); chk("forced_release_gnt1", 32'(gnt1), 32'd1);
        // lock alone past MAX_HOLD saturates, then yields immediately
        step; drv1(0, 0, 0, 0, 0); push_g(0, 1, 216, 5);
        step; drv0(1, 1, 1, 220, 6); push_g(0, 1, 220, 6);
        step; drv0(1, 1, 1, 224, 7); push_g(0, 1, 224, 7);
        step; drv0(1, 1, 1, 228, 8); push_g(0, 1, 228, 8);
        step; drv0(1, 1, 1, 232, 9); push_g(0, 1, 232, 9);
        step; drv0(1, 1, 1, 236, 10); drv1(1, 1, 0, 304, 10); push_g(1, 1, 304, 10);
        @(negedge clk); chk("sat_release_gnt1", 32'(gnt1), 32'd1);
        step; drv1(0, 0, 0, 0, 0); push_g(0, 1, 236, 10);
        step; drv0(0, 0, 0, 0, 0);
        // reset right after a granted locked read
        step; drv0(1, 0, 1, 400, 0); mem_rdata = 32'hBEEF; push_g(0, 0, 400, 0);
        step; reset = 1'b0; drv0(1, 1, 1, 504, 4); drv1(1, 1, 0, 500, 3);
        @(negedge clk);
        chk("midrst_gnt0", 32'(gnt0), 32'd0);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        step; reset = 1'b1; push_g(0, 1, 504, 4);
        @(negedge clk);
        chk("midrst_rvalid0", 32'(rvalid0), 32'd0);
        chk("midrst_gnt0_first", 32'(gnt0), 32'd1);
        step; drv0(0, 0, 0, 0, 0); push_g(1, 1, 500, 3);
        step; drv1(0, 0, 0, 0, 0);
        step; step;
        @(negedge clk);
        chk("grants_drained", 32'(gq.size()), 32'd0);
        chk("reads_drained", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/combi_dmem_arbiter.md
Name: combi_dmem_arbiter

Overview:
- Shares one single-ported data memory between the two cores of the combined processor: port 0 is RISC-V, port 1 is ARM.
- Round-robin arbitration, zero-wait grant when uncontended.
- Optional bounded lock so one core can hold the memory for back-to-back accesses.
- Sits between the cores' data-bus outputs (address, write data, write enable) and the shared dmem.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_HOLD, 4, max consecutive locked grants to one port before forced release (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low; reset==0 on a clk edge resets all state
req0  in  1  port 0 (RISC-V) access request
we0  in  1  port 0 write enable
lock0  in  1  port 0 requests to keep the grant next cycle
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
gnt0  out  1  port 0 access accepted this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DW  port 0 read data
req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1 (ARM)
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after a read with mem_en=1

Behaviour:
- Registered state: last_gnt (1 bit, reset 1), lock_own (none/0/1, reset none), hold_cnt ($clog2(MAX_HOLD+1) bits, reset 0), rd_pend0/rd_pend1 (reset 0).
- While reset==0:
  - gnt0, gnt1, mem_en and mem_we are forced 0, regardless of req.
  - rvalid0 and rvalid1 are 0 on the cycle after the reset edge.
- Grant logic is combinational from req and registered state; at most one gnt per cycle.
  - Locked: if lock_own==N, reqN==1 and hold_cnt<MAX_HOLD, grant N; the other port waits.
  - Otherwise, only one req high: grant that port.
  - Otherwise, both req high: grant !last_gnt, so port 0 wins the first contest after reset.
  - No req: no grant.
- Granted cycle:
  - mem_en=1, mem_we=weN, mem_addr=addrN, mem_wdata=wdataN.
  - With no grant, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Requester rule: hold reqN, weN, addrN and wdataN stable until the cycle gntN=1. The transfer completes in that cycle.
- Read return:
  - rd_pendN <= gntN & !weN.
  - rvalidN = rd_pendN.
  - rdataN = rd_pendN ? mem_rdata : 0.
  - Read latency is exactly 1 cycle after the grant. Writes produce no rvalid.
- On each grant: last_gnt <= N.
- Lock tracking:
  - On a grant to N with lockN==1: lock_own <= N; hold_cnt <= (lock_own==N ? hold_cnt+1 : 1).
  - On a grant with lockN==0, or a cycle where the owner drops req: lock_own <= none, hold_cnt <= 0.
- Forced release: when hold_cnt==MAX_HOLD and the other port is requesting, the other port is granted; lock_own <= none, hold_cnt <= 0. If the other port is idle, the owner keeps being granted and hold_cnt saturates at MAX_HOLD.
- Reset mid-operation: pending reads are dropped (no rvalid), lock cleared, last_gnt back to 1.
- rvalidN and gntN may both be 1 in the same cycle (pipelined back-to-back reads). The bench must accept this.

Test Plan:
- Reset held low for 3 cycles with req0=req1=1 -> gnt0=gnt1=0 and mem_en=0 throughout; first cycle after release, gnt0=1.
- Port 0 alone writes addr 100 data 25 -> same cycle gnt0=1, mem_en=1, mem_we=1, mem_addr=100, mem_wdata=25; rvalid0 stays 0.
- Both ports request in the same cycle: port 0 writes addr 100 data 25, port 1 writes addr 100 data 7 -> cycle 1 gnt0 with mem_wdata=25; cycle 2 gnt1 with mem_wdata=7. With both requesting continuously, grants alternate 0,1,0,1.
- Port 1 reads addr 96 while mem_rdata returns 0x1234 -> gnt1 in cycle t; rvalid1=1 and rdata1=0x1234 in t+1; rdata0=0.
- Port 0 holds lock0=1 and req0=1 while req1=1, MAX_HOLD=4 -> gnt0 for 4 consecutive cycles, then gnt1 in cycle 5, and lock_own cleared.
- Port 0 read granted, reset pulled low the next cycle -> rvalid0=0 and lock cleared; after release, contested requests go to port 0 first.
